// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts one command byte (LSB first, odd parity, stop) out on the
// device-generated clock and checks the device ACK bit.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   synchronous, active-high
//   cmd_data    in   [7:0] byte to send, latched when the request is accepted
//   cmd_send    in   send request, accepted only while busy=0
//   ps2_clk_in  in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   busy        out  transaction in progress (held through the DONE/ERR cycle)
//   cmd_done    out  one-cycle pulse: ACK received and bus back to idle
//   cmd_error   out  one-cycle pulse: device timeout, packet timeout or NACK
module ps2_host_tx #(
  parameter int CLK_HOLD_CYCLES    = 5000,
  parameter int DEV_TIMEOUT_CYCLES = 750000,
  parameter int PKT_TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_error
);

  // One counter is shared by the hold, device-wait and packet timers since
  // those phases never overlap.
  localparam int CNT_AB  = (CLK_HOLD_CYCLES > DEV_TIMEOUT_CYCLES) ? CLK_HOLD_CYCLES : DEV_TIMEOUT_CYCLES;
  localparam int CNT_MAX = (CNT_AB > PKT_TIMEOUT_CYCLES) ? CNT_AB : PKT_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEV_LAST  = CW'(DEV_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PKT_LAST  = CW'(PKT_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REQ,
    ST_WAIT_DEV,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers: bit 0 = clock line, bit 1 = data line.
  // Reset to 1 so an idle (pulled-up) bus never looks like a falling edge.
  // ---------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {ps2_dat_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [1:0] stage_reg;
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          stage_reg <= 2'b11;
        end else begin
          stage_reg <= {stage_reg[0], pin_raw[gi]};
        end
      end
      assign pin_sync[gi] = stage_reg[1];
    end
  endgenerate

  logic clk_sync;
  logic dat_sync;
  logic clk_prev_reg;
  logic clk_fall;

  assign clk_sync = pin_sync[0];
  assign dat_sync = pin_sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= clk_sync;
    end
  end

  assign clk_fall = clk_prev_reg & ~clk_sync;

  // ---------------------------------------------------------------------
  // FSM
  // frame_reg holds {stop, parity, d7..d0}; bit 0 is the bit currently
  // presented on the data line while in ST_DATA.
  // ---------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [9:0]    frame_reg, frame_next;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      frame_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      frame_reg   <= frame_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    frame_next   = frame_reg;
    ps2_clk_oe   = 1'b0;
    ps2_dat_oe   = 1'b0;
    busy         = 1'b1;
    cmd_done     = 1'b0;
    cmd_error    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (cmd_send) begin
          frame_next   = {1'b1, ~^cmd_data, cmd_data};
          cnt_next     = '0;
          bit_cnt_next = '0;
          state_next   = ST_HOLD;
        end
      end

      ST_HOLD: begin
        ps2_clk_oe = 1'b1;
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = ST_REQ;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      // Start bit: data pulled low one cycle before the clock is released.
      ST_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        // The start-bit cycle already counts toward the device timeout.
        cnt_next   = CW'(1);
        state_next = ST_WAIT_DEV;
      end

      ST_WAIT_DEV: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          // Edge 1: present d0 (already in frame_reg[0]); packet timer starts.
          bit_cnt_next = 4'd1;
          cnt_next     = CW'(1);
          state_next   = ST_DATA;
        end else if (cnt_reg == DEV_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_DATA: begin
        ps2_dat_oe = ~frame_reg[0];
        if (cnt_reg == PKT_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (clk_fall) begin
            frame_next   = {1'b1, frame_reg[9:1]};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            // Edge 10 shifts the stop bit (released line) into place.
            if (bit_cnt_reg == 4'd9) begin
              state_next = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        if (cnt_reg == PKT_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (clk_fall) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            state_next   = dat_sync ? ST_ERR : ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (cnt_reg == PKT_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (clk_sync && dat_sync) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        cmd_done   = 1'b1;
        state_next = ST_IDLE;
      end

      ST_ERR: begin
        cmd_error  = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: the bench plays the keyboard on an open-drain bus,
// and a per-cycle compare thread checks all outputs against a timeline model
// built from accept time, device edge times and bus-release time.
module tb_ps2_host_tx;

  localparam int H   = 40;
  localparam int D   = 300;
  localparam int P   = 2000;
  localparam int BIG = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       dev_clk;
  logic       dev_dat;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       cmd_done;
  logic       cmd_error;

  always #5 clk = ~clk;

  // Wired-AND open-drain bus
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_HOLD_CYCLES   (H),
    .DEV_TIMEOUT_CYCLES(D),
    .PKT_TIMEOUT_CYCLES(P)
  ) u_dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .cmd_data  (cmd_data),
    .cmd_send  (cmd_send),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .cmd_done  (cmd_done),
    .cmd_error (cmd_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Transaction model: timeline of one command
  bit         m_active = 1'b0;
  int         m_t      = 0;      // cycle cmd_send was driven
  int         m_end    = 0;      // cycle of done/err pulse, or reset cycle
  int         m_kind   = 0;      // 0 done, 1 error, 2 aborted by reset
  logic [8:0] m_frame  = '0;     // {parity, byte}
  int         edge_cyc [12];     // cycle raw device clock went low, edges 1..11
  int         n_edges  = 0;
  int         n_done   = 0;
  int         n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected {clk_oe, dat_oe, busy, done, error} for cycle c
  function automatic logic [4:0] expect_out(input int c);
    int   k;
    logic d;
    if (!m_active || c <= m_t) return 5'b00000;
    if (c == m_end && m_kind != 2) return {3'b001, (m_kind == 0), (m_kind == 1)};
    if (c <= m_t + H) return 5'b10100;
    if (c == m_t + H + 1) return 5'b11100;
    k = 0;
    for (int i = 1; i <= n_edges; i++)
      if (edge_cyc[i] + 3 <= c) k++;
    if (k == 0)      d = 1'b1;
    else if (k <= 9) d = ~m_frame[k-1];
    else             d = 1'b0;
    return {1'b0, d, 1'b1, 2'b00};
  endfunction

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 4000) begin
      step(1);
      w++;
    end
    check("send_ready", {31'd0, busy}, 32'd0);
    cmd_data = b;
    cmd_send = 1'b1;
    m_t      = cyc;
    m_frame  = {~^b, b};
    n_edges  = 0;
    m_end    = cyc + 1 + H + D;
    m_kind   = 1;
    m_active = 1'b1;
    step(1);
    cmd_send = 1'b0;
    cmd_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (m_active && w < 4000) begin
      step(1);
      w++;
    end
    check("txn_finished", {31'd0, m_active}, 32'd0);
  endtask

  // Keyboard side of one transfer. samp[0] = start bit seen at request,
  // samp[1..10] = line sampled on device rising edges 1..10.
  task automatic dev_xfer(input int hp, input bit nack, input int abort_edge,
                          input bit poke, output logic [10:0] samp);
    int w;
    samp = '0;
    w = 0;
    while (ps2_clk_oe !== 1'b1 && w < H + D + 100) begin step(1); w++; end
    while (ps2_clk_oe !== 1'b0 && w < H + D + 100) begin step(1); w++; end
    check("dev_request_seen", {31'd0, (w < H + D + 100)}, 32'd1);
    if (w >= H + D + 100) return;
    samp[0] = ps2_dat_in;
    step(4);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        dev_dat = nack;
        step(4);
      end
      dev_clk     = 1'b0;
      edge_cyc[i] = cyc;
      n_edges     = i;
      if (i == 1) begin
        m_end  = BIG;
        m_kind = 0;
      end
      if (i == 11 && nack) begin
        m_end  = cyc + 3;
        m_kind = 1;
      end
      if (poke && i == 3) begin
        cmd_data = 8'h55;
        cmd_send = 1'b1;
        step(1);
        cmd_send = 1'b0;
        step(hp - 1);
      end else begin
        step(hp);
      end
      if (abort_edge == i) begin
        reset  = 1'b1;
        m_end  = cyc;
        m_kind = 2;
        step(1);
        check("abort_release", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 32'd0);
        reset   = 1'b0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      if (i == 11) begin
        dev_dat = 1'b1;
        if (!nack) begin
          m_end  = cyc + 3;
          m_kind = 0;
        end
      end else begin
        samp[i] = ps2_dat_in;
      end
      step(hp);
    end
  endtask

  initial begin
    logic [10:0] samp;
    logic [7:0]  b;
    int          d0, e0, hold, err_cyc, hp;
    bit          nack;

    reset    = 1'b1;
    cmd_send = 1'b0;
    cmd_data = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    step(3);

    fork
      forever begin
        @(negedge clk);
        if (m_active && cyc > m_end) m_active = 1'b0;
        check($sformatf("outputs@%0d", cyc),
              {27'd0, ps2_clk_oe, ps2_dat_oe, busy, cmd_done, cmd_error},
              {27'd0, expect_out(cyc)});
        if (cmd_done === 1'b1)  n_done++;
        if (cmd_error === 1'b1) n_err++;
      end
    join_none

    check("reset_state", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, cmd_done, cmd_error}, 32'd0);
    reset = 1'b0;
    step(2);

    // 0xED with a 0x55 request poked mid-transfer (must be ignored)
    d0 = n_done;
    send(8'hED);
    dev_xfer(10, 1'b0, 0, 1'b1, samp);
    wait_idle();
    $display("txn ED: samp=%03h done=%0d", samp, n_done - d0);
    check("ed_frame", {21'd0, samp}, 32'h7DA);
    check("ed_single_done", n_done - d0, 32'd1);

    // 0xF4: five ones -> parity 0
    d0 = n_done;
    send(8'hF4);
    dev_xfer(8, 1'b0, 0, 1'b0, samp);
    wait_idle();
    $display("txn F4: samp=%03h done=%0d", samp, n_done - d0);
    check("f4_parity", {31'd0, samp[9]}, 32'd0);
    check("f4_frame", {21'd0, samp}, 32'h5E8);
    check("f4_done", n_done - d0, 32'd1);

    // 0x00 -> parity 1
    d0 = n_done;
    send(8'h00);
    dev_xfer(6, 1'b0, 0, 1'b0, samp);
    wait_idle();
    $display("txn 00: samp=%03h done=%0d", samp, n_done - d0);
    check("zero_frame", {21'd0, samp}, 32'h600);
    check("zero_done", n_done - d0, 32'd1);

    // No device: hold length and timeout latency
    e0 = n_err;
    send(8'hA5);
    hold    = 0;
    err_cyc = -1;
    for (int i = 0; i < H + D + 20; i++) begin
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) hold++;
      if (cmd_error === 1'b1 && err_cyc < 0) err_cyc = cyc;
      step(1);
    end
    wait_idle();
    $display("txn nodev: hold=%0d err_latency=%0d", hold, err_cyc - m_t);
    check("nodev_hold", hold, 32'd40);
    check("nodev_err_latency", err_cyc - m_t, 32'd341);
    check("nodev_error", n_err - e0, 32'd1);

    // NACK
    d0 = n_done;
    e0 = n_err;
    send(8'h3C);
    dev_xfer(9, 1'b1, 0, 1'b0, samp);
    wait_idle();
    $display("txn nack: err=%0d done=%0d", n_err - e0, n_done - d0);
    check("nack_error", n_err - e0, 32'd1);
    check("nack_no_done", n_done - d0, 32'd0);

    // Reset after edge 4 of 0xFF, then 0xF4 completes
    d0 = n_done;
    e0 = n_err;
    send(8'hFF);
    dev_xfer(10, 1'b0, 4, 1'b0, samp);
    step(2);
    send(8'hF4);
    dev_xfer(10, 1'b0, 0, 1'b0, samp);
    wait_idle();
    $display("txn abort+F4: samp=%03h done=%0d err=%0d", samp, n_done - d0, n_err - e0);
    check("after_abort_frame", {21'd0, samp}, 32'h5E8);
    check("after_abort_done", n_done - d0, 32'd1);
    check("abort_no_error", n_err - e0, 32'd0);

    // Random bytes, device speeds and ACK/NACK, back-to-back sends
    for (int t = 0; t < 8; t++) begin
      b    = 8'($urandom);
      hp   = int'($urandom_range(12, 5));
      nack = ($urandom_range(3, 0) == 0);
      d0   = n_done;
      e0   = n_err;
      send(b);
      dev_xfer(hp, nack, 0, 1'b0, samp);
      wait_idle();
      $display("txn rnd %02h hp=%0d nack=%0d: samp=%03h done=%0d err=%0d",
               b, hp, nack, samp, n_done - d0, n_err - e0);
      check("rnd_frame", {21'd0, samp}, {21'd0, 1'b1, ~^b, b, 1'b0});
      check("rnd_result", nack ? (n_err - e0) : (n_done - d0), 32'd1);
    end

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
